// File: rtl/pe_pkg.sv
// Package for the PE row sequencer.
// Holds the sequencer state encoding, the default geometry (samples per block and
// PE row drain latency), and the two-pass signed coefficient table.
// Pass 0 row is the sum pass, pass 1 row is the difference pass.

package pe_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStream,
        StDrain
    } state_t;

    localparam int unsigned N_DEFAULT        = 8;
    localparam int unsigned PIPE_LAT_DEFAULT = 4;
    localparam int unsigned COEF_WIDTH       = 8;
    localparam int unsigned COEF_IDX_W       = $clog2(N_DEFAULT);

    // COEF[pass][column]
    localparam logic signed [COEF_WIDTH-1:0] COEF [2][N_DEFAULT] = '{
        '{8'sd3, -8'sd5, 8'sd7, -8'sd11, 8'sd13, -8'sd17, 8'sd19, -8'sd23},
        '{8'sd2, 8'sd4, -8'sd6, 8'sd8, -8'sd10, 8'sd12, -8'sd14, 8'sd16}
    };

    // Columns beyond the table read as zero so a wider N still elaborates.
    function automatic logic signed [COEF_WIDTH-1:0] coef_lookup(input logic pass,
                                                                 input int unsigned idx);
        logic signed [COEF_WIDTH-1:0] value;
        value = '0;
        if (idx < N_DEFAULT) begin
            value = COEF[pass][idx[COEF_IDX_W-1:0]];
        end
        return value;
    endfunction

endpackage

// File: rtl/pe_row_sequencer_if.sv
// Sample stream and PE row bus of the PE row sequencer.
//   s_valid / s_ready / s_data : input sample handshake (into the sequencer)
//   pe_x / pe_valid            : sample to the PE row and its qualifier
//   pe_z                       : partial-sum seed (constant zero)
//   pe_coefficient / pe_load   : serial coefficient bus and its shift-load strobe
//   pe_sumDiffSel              : 0 = sum pass, 1 = difference pass
// master = sequencer side, slave = sample source / PE row side.

interface pe_row_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic [DATA_WIDTH-1:0] pe_x;
    logic [DATA_WIDTH-1:0] pe_z;
    logic [DATA_WIDTH-1:0] pe_coefficient;
    logic                  pe_sumDiffSel;
    logic                  pe_load;
    logic                  pe_valid;

    modport master (
        input  s_valid,
        input  s_data,
        output s_ready,
        output pe_x,
        output pe_z,
        output pe_coefficient,
        output pe_sumDiffSel,
        output pe_load,
        output pe_valid
    );

    modport slave (
        output s_valid,
        output s_data,
        input  s_ready,
        input  pe_x,
        input  pe_z,
        input  pe_coefficient,
        input  pe_sumDiffSel,
        input  pe_load,
        input  pe_valid
    );

endinterface

// File: rtl/pe_coef_rom.sv
// Coefficient ROM with a registered read port.
// Ports:
//   clk, rst : clock and synchronous active-high reset (clears the output)
//   rd_en    : read strobe; when low the registered output returns to zero
//   pass     : table row (0 = sum, 1 = difference)
//   idx      : table column
//   rdata    : registered, sign-extended coefficient

module pe_coef_rom
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_en,
    input  logic                  pass,
    input  logic [IDX_W-1:0]      idx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_comb begin
        rdata_d = '0;
        if (rd_en) begin
            rdata_d = DATA_WIDTH'(coef_lookup(pass, 32'(idx)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pe_row_sequencer.sv
// PE row sequencer.
// A block runs two passes over N samples. Each pass loads N coefficients serially
// into the PE columns, streams N samples into the row, then waits PIPE_LAT cycles
// for the row to drain. Pass 0 takes samples from the input handshake and keeps a
// copy; pass 1 replays that copy without stalls. done_o pulses once per block.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start_i  : one-cycle block start, honoured only when idle
//   bus      : sample handshake and PE row bus (master side)
//   busy_o   : high while a block is in progress (registered)
//   done_o   : one-cycle block-complete pulse (registered)

module pe_row_sequencer
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N          = N_DEFAULT,
    parameter int unsigned PIPE_LAT   = PIPE_LAT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    pe_row_sequencer_if.master bus,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned CNT_MAX = (N > PIPE_LAT) ? N : PIPE_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = (N > 1) ? $clog2(N) : 1;

    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN  = CNT_W'(PIPE_LAT - 1);

    state_t           state_q, state_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx;

    logic [DATA_WIDTH-1:0] buffer_q [N];
    logic                  buf_we;

    logic                  s_ready;
    logic                  handshake;
    logic                  advance;

    logic [DATA_WIDTH-1:0] pe_x_q, pe_x_d;
    logic                  pe_load_q, pe_load_d;
    logic                  pe_valid_q, pe_valid_d;
    logic                  pe_sel_q;
    logic                  busy_q;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] pe_coef;

    // Sample and coefficient index; the counter is wider only to cover DRAIN.
    assign idx = cnt_q[IDX_W-1:0];

    // s_ready is decoded straight from registered state so the source sees it
    // in the same cycle the sequencer is able to take a sample.
    assign s_ready   = (state_q == StStream) && !pass_q;
    assign handshake = bus.s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        cnt_d      = cnt_q;
        pe_x_d     = pe_x_q;
        pe_load_d  = 1'b0;
        pe_valid_d = 1'b0;
        done_d     = 1'b0;
        buf_we     = 1'b0;
        advance    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                end
            end

            StLoad: begin
                pe_load_d = 1'b1;
                if (cnt_q == LAST_SAMPLE) begin
                    state_d = StStream;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StStream: begin
                if (!pass_q) begin
                    if (handshake) begin
                        buf_we     = 1'b1;
                        pe_x_d     = bus.s_data;
                        pe_valid_d = 1'b1;
                        advance    = 1'b1;
                    end
                end else begin
                    pe_x_d     = buffer_q[idx];
                    pe_valid_d = 1'b1;
                    advance    = 1'b1;
                end
                if (advance) begin
                    if (cnt_q == LAST_SAMPLE) begin
                        state_d = StDrain;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            StDrain: begin
                if (cnt_q == LAST_DRAIN) begin
                    cnt_d = '0;
                    if (!pass_q) begin
                        pass_d  = 1'b1;
                        state_d = StLoad;
                    end else begin
                        pass_d  = 1'b0;
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            pass_q     <= 1'b0;
            cnt_q      <= '0;
            pe_x_q     <= '0;
            pe_load_q  <= 1'b0;
            pe_valid_q <= 1'b0;
            pe_sel_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_q     <= pass_d;
            cnt_q      <= cnt_d;
            pe_x_q     <= pe_x_d;
            pe_load_q  <= pe_load_d;
            pe_valid_q <= pe_valid_d;
            pe_sel_q   <= pass_q;
            busy_q     <= (state_q != StIdle);
            done_q     <= done_d;
        end
    end

    // Sample buffer is plain storage; contents are always written before use.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buffer_q[idx] <= bus.s_data;
        end
    end

    // The ROM output register sits at the same stage as pe_load_q, keeping the
    // coefficient and its strobe aligned.
    pe_coef_rom #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_coef_rom (
        .clk   (clk),
        .rst   (rst),
        .rd_en (state_q == StLoad),
        .pass  (pass_q),
        .idx   (idx),
        .rdata (pe_coef)
    );

    assign bus.s_ready        = s_ready;
    assign bus.pe_x           = pe_x_q;
    assign bus.pe_z           = '0;
    assign bus.pe_coefficient = pe_coef;
    assign bus.pe_sumDiffSel  = pe_sel_q;
    assign bus.pe_load        = pe_load_q;
    assign bus.pe_valid       = pe_valid_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;

endmodule

// File: doc/pe_row_sequencer.md
PE_ROW_SEQUENCER -- requirements
Module: pe_row_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: sample and coefficient width.
REQ-002 SHALL have parameter N, default 8: samples per block and PE columns.
REQ-003 SHALL have parameter PIPE_LAT, default 4: PE row drain cycles per pass.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port start_i, input, 1: one-cycle block start request.
REQ-007 SHALL have port s_valid, input, 1: input sample valid.
REQ-008 SHALL have port s_ready, output, 1: sequencer accepts a sample.
REQ-009 SHALL have port s_data, input, DATA_WIDTH: input sample.
REQ-010 SHALL have port pe_x, output, DATA_WIDTH: sample to PE row.
REQ-011 SHALL have port pe_z, output, DATA_WIDTH: partial-sum seed to PE row, constant 0.
REQ-012 SHALL have port pe_coefficient, output, DATA_WIDTH: serial coefficient bus to PE columns.
REQ-013 SHALL have port pe_sumDiffSel, output, 1: 0 = sum pass, 1 = difference pass.
REQ-014 SHALL have port pe_load, output, 1: coefficient shift-load strobe.
REQ-015 SHALL have port pe_valid, output, 1: pe_x qualifier.
REQ-016 SHALL have ports busy_o, output, 1 (not IDLE) and done_o, output, 1 (block-complete pulse).

Function
REQ-017 SHALL implement FSM IDLE, LOAD, STREAM, DRAIN with a 1-bit pass register and a counter of width clog2(max(N, PIPE_LAT)+1).
REQ-018 IDLE: s_ready=0; start_i -> LOAD with pass=0, cnt=0; start_i outside IDLE SHALL be ignored.
REQ-019 LOAD: exactly N cycles, cnt 0..N-1; each cycle drives pe_load=1 and pe_coefficient=COEF[pass][cnt]; pe_valid=0; after cnt=N-1 -> STREAM, cnt=0.
REQ-020 STREAM, pass 0: s_ready=1; each handshake (s_valid&&s_ready) writes s_data to buffer[cnt], drives pe_x=s_data and pe_valid=1, cnt++; no handshake -> pe_valid=0, cnt holds.
REQ-021 STREAM, pass 1: s_ready=0; each cycle drives pe_x=buffer[cnt] and pe_valid=1, cnt++; no stalls.
REQ-022 After the N-th sample of a pass -> DRAIN, cnt=0; DRAIN SHALL last PIPE_LAT cycles with pe_valid=0 and pe_load=0.
REQ-023 DRAIN end: pass 0 -> pass=1, LOAD; pass 1 -> IDLE with done_o=1 for exactly one cycle.
REQ-024 pe_sumDiffSel SHALL equal pass, held stable for the whole pass, including LOAD and DRAIN.
REQ-025 All pe_* outputs, done_o and busy_o SHALL be registered, lagging FSM state by one cycle; pe_load and pe_coefficient SHALL be mutually aligned.
REQ-026 pe_x SHALL hold its last value when pe_valid=0; pe_load and pe_valid SHALL never both be 1.
REQ-027 The sample buffer SHALL hold N x DATA_WIDTH and be overwritten only in pass-0 STREAM.

Reset
REQ-028 rst SHALL force IDLE, pass=0, cnt=0, and all outputs to 0 on the next edge, including mid-block; the partial block is discarded and done_o is not raised.
REQ-029 Buffer contents SHALL NOT require reset.

Structure
REQ-030 Package pe_pkg SHALL hold the state enum, the defaults for N and PIPE_LAT, and the COEF[2][N] signed coefficient table.
REQ-031 The coefficient table SHALL be a sub-module pe_coef_rom with a registered read output indexed by {pass, cnt}.

Verification
REQ-032 Scenario 1: start at cycle 0, s_valid held high with data 1..8 -> pe_load high 8 cycles with sumDiffSel=0; pe_valid high 8 cycles with x=1..8; 4 idle cycles; pe_load 8 cycles with sumDiffSel=1; replayed x=1..8; 4 idle cycles; done_o one pulse, 40 cycles after LOAD entry.
REQ-033 Scenario 2: same block with s_valid low every other cycle -> pe_valid follows the handshakes, x order 1..8 preserved, pass-1 replay unstalled.
REQ-034 Scenario 3: start_i pulsed during STREAM and DRAIN -> no effect; exactly one done_o.
REQ-035 Scenario 4: rst asserted at the 3rd pass-1 replay cycle -> next cycle all outputs 0, busy_o=0, no done_o; a new start then completes normally.
REQ-036 Scenario 5: back-to-back blocks, start_i in the cycle after done_o, data 0x80..0x87 -> second block accepted with correct coefficients and no buffer corruption from block 1.
